hamming_secded_encoder: RTL and testbench
=========================================

// Module: hamming_secded_encoder
// PURPOSE
//  Streaming Hamming encoder, parametrised in data width, with SEC/SECDED mode select.
//  Pulls message words from the message buffer FIFO (1-cycle read latency) and encodes each one.
//  Emits one padded codeword per cycle to the modulator over a valid/ready interface.
//  Has a single-shot error-injection port so that decoder benches can exercise the correction path.
// PARAMETERS
//  DATA_WIDTH   8   message bits per word.
//  PARITY_BITS  5   Hamming bits r (smallest r with 2^r >= DATA_WIDTH+r+1) plus 1 overall bit.
//  CODE_WIDTH   DATA_WIDTH+PARITY_BITS (localparam)   meaningful codeword bits.
//  OUT_WIDTH    16  padded output width (HAMMING_WIDTH); must be >= CODE_WIDTH.
// PORTS
//  clk            in   1             system clock; all logic on posedge.
//  rst            in   1             asynchronous, active-high reset.
//  fifo_empty     in   1             message FIFO empty flag.
//  fifo_rd_en     out  1             FIFO read strobe.
//  fifo_rd_data   in   DATA_WIDTH    FIFO read data; valid when fifo_rd_valid is high.
//  fifo_rd_valid  in   1             high exactly 1 cycle after an accepted fifo_rd_en.
//  secded_en      in   1             1: compute the overall parity bit 0; 0: bit 0 forced to 0. Sampled on the fifo_rd_valid cycle.
//  inj_req        in   1             pulse: arm a single-bit flip on the next codeword.
//  inj_pos        in   $clog2(OUT_WIDTH)  bit index to flip; sampled together with inj_req.
//  inj_ack        out  1             1-cycle pulse when an armed injection is consumed.
//  enc_valid      out  1             head of the output buffer holds a codeword.
//  enc_ready      in   1             downstream accepts the codeword.
//  enc_data       out  OUT_WIDTH     codeword (encoded_message_data_t).
//  cw_count       out  16            count of accepted codewords; wraps at 2^16.
// BEHAVIOUR
//  Reset: fifo_rd_en, inj_ack, enc_valid, enc_data, cw_count all 0. Output buffer emptied, credits reset, injection disarmed.
//   Reset mid-operation drops any in-flight read and any buffered words.
//  Flow control: 2-entry output buffer. credits = 2 - (occupied + outstanding reads).
//   fifo_rd_en = !fifo_empty && credits>0 (counting a same-cycle pop as a free slot).
//  Latency: fifo_rd_en at cycle t -> fifo_rd_valid at t+1 -> enc_valid at t+2.
//   Sustains 1 word/cycle while enc_ready stays high.
//  Encode (combinational, on the fifo_rd_valid cycle): classic Hamming positions 1..CODE_WIDTH-1.
//   Parity bits sit at power-of-2 positions; data bits fill the remaining positions in ascending order, LSB first.
//   Parity bit p_k = even parity over the positions whose index has bit k set.
//   Bit 0 = XOR of bits 1..CODE_WIDTH-1 when secded_en=1, else 0.
//   Bits CODE_WIDTH..OUT_WIDTH-1 are 0.
//  Buffer: written on fifo_rd_valid; popped on enc_valid && enc_ready. Simultaneous push and pop is legal.
//   Push while full cannot occur (credits prevent it); an SVA asserts this.
//   fifo_rd_valid with no outstanding read is an assertion error; the data is dropped.
//  enc_data and enc_valid stay stable while enc_valid && !enc_ready.
//  Injection: inj_req arms the flip and latches inj_pos. inj_req while already armed is ignored.
//   The next buffer push XORs bit inj_pos and pulses inj_ack in the same cycle.
//   If inj_pos >= CODE_WIDTH, no bit is flipped but inj_ack still pulses.
//   If inj_req coincides with a push, the flip applies to the following push.
//  cw_count increments on every enc_valid && enc_ready and wraps 0xFFFF -> 0x0000.
// STRUCTURE
//  encoder_fec_pkg: DATA_WIDTH, PARITY_BITS, HAMMING_WIDTH (=16, fixing the missing ';').
//   Also function hamming_r(k), message_data_t, encoded_message_data_t.
//  Sub-module hamming_parity_gen: purely combinational (data, secded_en) -> codeword.
//   Reused later by the decoder's syndrome check.
//  Top module holds the credit counter, the 2-entry buffer, the injection register and cw_count.
// TESTING (DATA_WIDTH=8)
//  1. 0x00, secded_en=1 -> enc_data 0x0000. Then 0xFF -> 0x1EEE.
//  2. 0x01: secded_en=1 -> 0x000F; secded_en=0 -> 0x000E.
//  3. Fill FIFO via write_complete_buffer, enc_ready=1 -> codewords match the reference model in order.
//     First enc_valid at t+2; one word per cycle; cw_count = words written.
//  4. enc_ready toggled randomly -> no loss, duplication or reordering. fifo_rd_en never leaves >2 words in flight.
//     enc_data stable while stalled.
//  5. inj_req with inj_pos=3, then 0xFF -> 0x1EE6 and inj_ack pulses once.
//     inj_pos=14 -> 0x1EEE, ack pulses. Second inj_req while armed has no effect.
//  6. rst asserted asynchronously mid-stream with buffer full -> all outputs 0 immediately.
//     After release, streaming resumes from the next FIFO word; cw_count restarts at 0.

Source files
------------

// File: rtl/encoder_fec_pkg.sv
// Shared constants, types and helpers for the Hamming FEC encoder and its decoder.
package encoder_fec_pkg;

    localparam int DATA_WIDTH    = 8;
    localparam int PARITY_BITS   = 5;
    localparam int HAMMING_WIDTH = 16;

    typedef logic [DATA_WIDTH-1:0]    message_data_t;
    typedef logic [HAMMING_WIDTH-1:0] encoded_message_data_t;

    // Smallest r with 2^r >= k + r + 1 (Hamming check bits, no overall bit).
    function automatic int hamming_r(input int k);
        int r;
        r = 31;
        for (int i = 30; i >= 1; i--) begin
            if ((1 << i) >= k + i + 1) r = i;
        end
        return r;
    endfunction

endpackage

// File: rtl/hamming_parity_gen.sv
// Combinational Hamming/SECDED codeword builder: data bits at non-power-of-2
// positions, check bits at power-of-2 positions, optional overall parity at bit 0.
module hamming_parity_gen #(
    parameter int DATA_WIDTH  = encoder_fec_pkg::DATA_WIDTH,
    parameter int PARITY_BITS = encoder_fec_pkg::PARITY_BITS,
    parameter int OUT_WIDTH   = encoder_fec_pkg::HAMMING_WIDTH,
    localparam int CODE_WIDTH = DATA_WIDTH + PARITY_BITS
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  secded_en,
    output logic [OUT_WIDTH-1:0]  codeword
);

    localparam int R = encoder_fec_pkg::hamming_r(DATA_WIDTH);

    function automatic logic [OUT_WIDTH-1:0] encode(input logic [DATA_WIDTH-1:0] d,
                                                    input logic               sec);
        logic [OUT_WIDTH-1:0] cw;
        logic                 p;
        int                   di;
        cw = '0;
        di = 0;
        // Scatter data LSB-first over the non-power-of-2 positions.
        for (int pos = 1; pos < CODE_WIDTH; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                cw[pos] = d[di];
                di++;
            end
        end
        // Each check bit covers the positions whose index has its bit set;
        // the other check positions never overlap, so order does not matter.
        for (int k = 0; k < R; k++) begin
            p = 1'b0;
            for (int pos = 1; pos < CODE_WIDTH; pos++) begin
                if (((pos >> k) & 1) == 1) p = p ^ cw[pos];
            end
            cw[1 << k] = p;
        end
        // Overall parity makes the whole codeword even for double-error detection.
        if (sec) cw[0] = ^cw;
        return cw;
    endfunction

    // Pure function of the inputs; no state.
    always_comb begin
        codeword = encode(data, secded_en);
    end

endmodule

// File: rtl/hamming_secded_encoder.sv
// Streaming SEC/SECDED encoder: credit-based reads from the message FIFO,
// 2-entry output buffer, single-shot bit-flip injection, accepted-word counter.
module hamming_secded_encoder #(
    parameter int DATA_WIDTH  = encoder_fec_pkg::DATA_WIDTH,
    parameter int PARITY_BITS = encoder_fec_pkg::PARITY_BITS,
    parameter int OUT_WIDTH   = encoder_fec_pkg::HAMMING_WIDTH,
    localparam int CODE_WIDTH = DATA_WIDTH + PARITY_BITS,
    localparam int POS_WIDTH  = $clog2(OUT_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                  fifo_rd_valid,
    input  logic                  secded_en,
    input  logic                  inj_req,
    input  logic [POS_WIDTH-1:0]  inj_pos,
    output logic                  inj_ack,
    output logic                  enc_valid,
    input  logic                  enc_ready,
    output logic [OUT_WIDTH-1:0]  enc_data,
    output logic [15:0]           cw_count
);

    logic [OUT_WIDTH-1:0] codeword;
    logic [OUT_WIDTH-1:0] push_word;
    logic [OUT_WIDTH-1:0] mem [2];
    logic [1:0]           count;
    logic                 head;
    logic                 rd_pending;
    logic                 inj_armed;
    logic [POS_WIDTH-1:0] inj_pos_q;
    logic                 push;
    logic                 pop;
    logic [2:0]           slots_used;
    logic [2:0]           slots_cap;

    hamming_parity_gen #(
        .DATA_WIDTH  (DATA_WIDTH),
        .PARITY_BITS (PARITY_BITS),
        .OUT_WIDTH   (OUT_WIDTH)
    ) u_parity_gen (
        .data      (fifo_rd_data),
        .secded_en (secded_en),
        .codeword  (codeword)
    );

    // A stray read-valid with no read outstanding is dropped, not buffered.
    assign push      = fifo_rd_valid && rd_pending;
    assign enc_valid = (count != 2'd0);
    assign pop       = enc_valid && enc_ready;
    assign enc_data  = enc_valid ? mem[head] : '0;
    assign inj_ack   = push && inj_armed;

    // Credits: buffered words plus the outstanding read must stay within the
    // two slots; a word leaving this cycle frees its slot for a new read.
    always_comb begin
        slots_used = {1'b0, count} + {2'b0, rd_pending};
        slots_cap  = 3'd2 + {2'b0, pop};
        fifo_rd_en = !rst && !fifo_empty && (slots_used < slots_cap);
    end

    // Apply an armed flip to the word being buffered; out-of-range positions flip nothing.
    always_comb begin
        push_word = codeword;
        if (inj_armed && (int'(inj_pos_q) < CODE_WIDTH)) begin
            push_word[inj_pos_q] = ~codeword[inj_pos_q];
        end
    end

    // Control state: buffer occupancy, read tracking, injection arm and word counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count      <= 2'd0;
            head       <= 1'b0;
            rd_pending <= 1'b0;
            inj_armed  <= 1'b0;
            inj_pos_q  <= '0;
            cw_count   <= 16'd0;
        end else begin
            // NOTE: non-blocking assignments here so every register sees the pre-edge values.
            rd_pending <= fifo_rd_en;
            count      <= count + {1'b0, push} - {1'b0, pop};
            if (pop) begin
                head     <= ~head;
                cw_count <= cw_count + 16'd1;
            end
            if (inj_ack) begin
                inj_armed <= 1'b0;
            end else if (inj_req && !inj_armed) begin
                inj_armed <= 1'b1;
                inj_pos_q <= inj_pos;
            end
        end
    end

    // Buffer storage; write slot is the one just behind the head.
    // NOTE: the data array has no reset - occupancy is reset and enc_data is masked while empty.
    always_ff @(posedge clk) begin
        if (push) mem[head ^ count[0]] <= push_word;
    end

    a_no_push_when_full : assert property (@(posedge clk) disable iff (rst)
        push |-> (count != 2'd2));
    a_valid_has_read : assert property (@(posedge clk) disable iff (rst)
        fifo_rd_valid |-> rd_pending);

endmodule

// File: tb/tb_hamming_secded_encoder.sv
// Self-checking bench: vector table, scoreboard against a syndrome-based
// reference encoder, random back-pressure and injection, async reset mid-stream.
module tb_hamming_secded_encoder;

    localparam int DW     = 8;
    localparam int OW     = 16;
    localparam int CODE_W = 13;

    logic          clk;
    logic          rst;
    logic          fifo_empty;
    logic          fifo_rd_en;
    logic [DW-1:0] fifo_rd_data;
    logic          fifo_rd_valid;
    logic          secded_en;
    logic          inj_req;
    logic [3:0]    inj_pos;
    logic          inj_ack;
    logic          enc_valid;
    logic          enc_ready;
    logic [OW-1:0] enc_data;
    logic [15:0]   cw_count;

    hamming_secded_encoder dut (
        .clk           (clk),
        .rst           (rst),
        .fifo_empty    (fifo_empty),
        .fifo_rd_en    (fifo_rd_en),
        .fifo_rd_data  (fifo_rd_data),
        .fifo_rd_valid (fifo_rd_valid),
        .secded_en     (secded_en),
        .inj_req       (inj_req),
        .inj_pos       (inj_pos),
        .inj_ack       (inj_ack),
        .enc_valid     (enc_valid),
        .enc_ready     (enc_ready),
        .enc_data      (enc_data),
        .cw_count      (cw_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        logic          sec;
        logic [OW-1:0] cw;
    } vec_t;

    vec_t          vecs[8];
    int            checks = 0;
    int            failures = 0;
    int            cyc = 0;
    int            accepted = 0;
    int            acc_since_rst = 0;
    int            ack_count = 0;
    int            first_rd = -1;
    int            first_val = -1;
    int            first_acc = -1;
    int            last_acc_cyc = -1;
    logic [OW-1:0] last_accepted = '0;
    logic [OW-1:0] first_after_rst = '0;
    logic [OW-1:0] exp_q[$];
    logic [DW-1:0] fifo_q[$];
    logic          m_armed = 1'b0;
    logic [3:0]    m_pos = '0;
    logic          prev_stall = 1'b0;
    logic [OW-1:0] prev_data = '0;
    logic          rd_en_seen = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: place data bits, then choose check bits so the XOR of the
    // indices of all set positions is zero; overall bit gives even weight.
    function automatic logic [OW-1:0] ref_encode(input logic [DW-1:0] d, input logic sec);
        logic [OW-1:0] cw;
        int            syn;
        int            di;
        cw  = '0;
        syn = 0;
        di  = 0;
        for (int pos = 1; pos < CODE_W; pos++) begin
            if ($countones(pos) != 1) begin
                if (d[di]) begin
                    cw[pos] = 1'b1;
                    syn = syn ^ pos;
                end
                di++;
            end
        end
        for (int k = 0; k < 4; k++) if (syn[k]) cw[1 << k] = 1'b1;
        if (sec) cw[0] = (($countones(cw) % 2) == 1);
        return cw;
    endfunction

    task automatic push_word(input logic [DW-1:0] w);
        fifo_q.push_back(w);
        fifo_empty = 1'b0;
    endtask

    task automatic write_complete_buffer(input int n);
        for (int i = 0; i < n; i++) push_word(DW'($urandom));
    endtask

    // Negedge observation: scoreboard, stall stability, injection model, in-flight bound.
    task automatic observe();
        logic          pop;
        logic          push;
        logic          exp_ack;
        logic [OW-1:0] exp;
        if (rst) begin
            rd_en_seen = 1'b0;
            prev_stall = 1'b0;
            return;
        end
        pop  = enc_valid && enc_ready;
        push = fifo_rd_valid;
        if (prev_stall) check("stall_hold", {15'd0, enc_valid, enc_data}, {15'd0, 1'b1, prev_data});
        if (fifo_empty) check("rd_en_while_empty", {31'd0, fifo_rd_en}, 32'd0);
        if (enc_valid && first_val < 0) first_val = cyc;
        if (fifo_rd_en && first_rd < 0) first_rd = cyc;
        if (pop) begin
            if (exp_q.size() == 0) check("stream_unexpected_word", exp_q.size(), 1);
            else check("stream_data", enc_data, exp_q.pop_front());
            accepted++;
            acc_since_rst++;
            if (acc_since_rst == 1) first_after_rst = enc_data;
            last_accepted = enc_data;
            last_acc_cyc = cyc;
            if (first_acc < 0) first_acc = cyc;
        end
        exp_ack = push && m_armed;
        check("inj_ack", {31'd0, inj_ack}, {31'd0, exp_ack});
        if (inj_ack) ack_count++;
        if (push) begin
            exp = ref_encode(fifo_rd_data, secded_en);
            if (exp_ack && m_pos < CODE_W) exp[m_pos] = ~exp[m_pos];
            exp_q.push_back(exp);
        end
        if (exp_ack) m_armed = 1'b0;
        else if (inj_req && !m_armed) begin
            m_armed = 1'b1;
            m_pos = inj_pos;
        end
        if (exp_q.size() + int'(fifo_rd_en) > 2) check("in_flight", exp_q.size() + int'(fifo_rd_en), 2);
        prev_stall = enc_valid && !enc_ready;
        prev_data  = enc_data;
        rd_en_seen = fifo_rd_en && (fifo_q.size() > 0);
    endtask

    // One clock: observe at negedge, then FIFO model answers 1 after the edge.
    task automatic cycle();
        @(negedge clk);
        observe();
        @(posedge clk);
        #1;
        cyc++;
        fifo_rd_valid = rd_en_seen;
        if (rd_en_seen) fifo_rd_data = fifo_q.pop_front();
        fifo_empty = (fifo_q.size() == 0);
    endtask

    task automatic run_until(input string name, input int target, input int budget);
        int n;
        n = 0;
        while (accepted < target && n < budget) begin
            cycle();
            n++;
        end
        check(name, accepted, target);
    endtask

    initial begin
        int base;
        int acks0;
        logic [DW-1:0] next_word;

        vecs[0] = '{8'h00, 1'b1, 16'h0000};
        vecs[1] = '{8'hFF, 1'b1, 16'h1EEE};
        vecs[2] = '{8'h01, 1'b1, 16'h000F};
        vecs[3] = '{8'h01, 1'b0, 16'h000E};
        vecs[4] = '{8'hFF, 1'b0, 16'h1EEE};
        vecs[5] = '{8'h80, 1'b1, 16'h1111};
        vecs[6] = '{8'h80, 1'b0, 16'h1110};
        vecs[7] = '{8'h02, 1'b1, 16'h0033};

        rst = 1'b1;
        fifo_empty = 1'b1;
        fifo_rd_data = '0;
        fifo_rd_valid = 1'b0;
        secded_en = 1'b1;
        inj_req = 1'b0;
        inj_pos = '0;
        enc_ready = 1'b1;

        // Reset state, with the FIFO claiming data so the read gate is exercised.
        repeat (2) @(posedge clk);
        fifo_empty = 1'b0;
        #1;
        check("reset_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        check("reset_valid", {31'd0, enc_valid}, 32'd0);
        check("reset_data", enc_data, 32'd0);
        check("reset_count", cw_count, 32'd0);
        check("reset_ack", {31'd0, inj_ack}, 32'd0);
        fifo_empty = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycle();

        // Directed vectors, one word at a time.
        for (int i = 0; i < 8; i++) begin
            secded_en = vecs[i].sec;
            push_word(vecs[i].data);
            run_until("vec_accept", accepted + 1, 10);
            check($sformatf("vec%0d", i), last_accepted, vecs[i].cw);
        end
        secded_en = 1'b1;

        // Burst: latency, throughput, counter.
        first_rd = -1;
        first_val = -1;
        first_acc = -1;
        base = accepted;
        write_complete_buffer(20);
        run_until("burst_accept", base + 20, 100);
        check("burst_latency", first_val - first_rd, 2);
        check("burst_rate", last_acc_cyc - first_acc, 19);
        check("burst_cw_count", cw_count, acc_since_rst);

        // Injection: in-range flip, out-of-range position, request while armed.
        inj_pos = 4'd3;
        inj_req = 1'b1;
        cycle();
        inj_req = 1'b0;
        acks0 = ack_count;
        push_word(8'hFF);
        run_until("inj3_accept", accepted + 1, 10);
        check("inj3_data", last_accepted, 16'h1EE6);
        check("inj3_acks", ack_count - acks0, 1);

        inj_pos = 4'd14;
        inj_req = 1'b1;
        cycle();
        inj_req = 1'b0;
        acks0 = ack_count;
        push_word(8'hFF);
        run_until("inj14_accept", accepted + 1, 10);
        check("inj14_data", last_accepted, 16'h1EEE);
        check("inj14_acks", ack_count - acks0, 1);

        inj_pos = 4'd3;
        inj_req = 1'b1;
        cycle();
        inj_pos = 4'd5;
        cycle();
        inj_req = 1'b0;
        acks0 = ack_count;
        push_word(8'hFF);
        run_until("inj_rearm_accept", accepted + 1, 10);
        check("inj_rearm_data", last_accepted, 16'h1EE6);
        push_word(8'hFF);
        run_until("inj_after_accept", accepted + 1, 10);
        check("inj_after_data", last_accepted, 16'h1EEE);
        check("inj_rearm_acks", ack_count - acks0, 1);

        // Random back-pressure, secded_en and injections against the scoreboard.
        base = accepted;
        for (int i = 0; i < 40; i++) push_word(DW'($urandom));
        for (int n = 0; n < 2000 && accepted < base + 40; n++) begin
            enc_ready = 1'($urandom_range(0, 1));
            secded_en = 1'($urandom_range(0, 1));
            inj_req   = ($urandom_range(0, 7) == 0);
            inj_pos   = 4'($urandom_range(0, 15));
            cycle();
        end
        inj_req = 1'b0;
        secded_en = 1'b1;
        check("random_accepted", accepted - base, 40);
        check("random_cw_count", cw_count, acc_since_rst);

        // Asynchronous reset with the output buffer full.
        enc_ready = 1'b0;
        for (int i = 0; i < 5; i++) push_word(DW'($urandom));
        repeat (8) cycle();
        check("prereset_valid", {31'd0, enc_valid}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        check("async_rst_valid", {31'd0, enc_valid}, 32'd0);
        check("async_rst_data", enc_data, 32'd0);
        check("async_rst_count", cw_count, 32'd0);
        check("async_rst_ack", {31'd0, inj_ack}, 32'd0);
        exp_q.delete();
        m_armed = 1'b0;
        prev_stall = 1'b0;
        acc_since_rst = 0;
        repeat (2) cycle();
        rst = 1'b0;
        enc_ready = 1'b1;
        next_word = fifo_q[0];
        for (int i = 0; i < 3; i++) push_word(DW'($urandom));
        run_until("post_reset_accept", accepted + fifo_q.size(), 100);
        check("post_reset_first", first_after_rst, ref_encode(next_word, 1'b1));
        check("post_reset_cw_count", cw_count, acc_since_rst);
        repeat (3) cycle();
        check("drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
